// File: rtl/ptp_up_reg_slave_if.sv
// Host register bus for the PTP clock block: one-cycle wr/rd strobes,
// byte address, write data and registered read data.
interface ptp_up_reg_slave_if;
  logic        wr_in;
  logic        rd_in;
  logic [7:0]  addr_in;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output wr_in, rd_in, addr_in, data_in,
    input  data_out
  );

  modport slave (
    input  wr_in, rd_in, addr_in, data_in,
    output data_out
  );
endinterface

// File: rtl/ptp_up_reg_slave.sv
// Register target for the PTP clock block: RTC staging and load strobes,
// time snapshot, and a timestamp FIFO drained by the host with a level IRQ.
module ptp_up_reg_slave #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ptp_up_reg_slave_if.slave    bus,
  input  logic [47:0]          time_sec_in,
  input  logic [31:0]          time_ns_in,
  output logic [47:0]          time_set_sec_out,
  output logic [31:0]          time_set_ns_out,
  output logic                 time_set_out,
  output logic [31:0]          period_out,
  output logic                 period_set_out,
  input  logic                 ts_valid_in,
  input  logic [47:0]          ts_sec_in,
  input  logic [31:0]          ts_ns_in,
  output logic                 irq_out
);

  // Word addresses (byte address bits [7:2])
  typedef enum logic [5:0] {
    REG_CTRL       = 6'h00,
    REG_STATUS     = 6'h01,
    REG_SET_SEC_H  = 6'h02,
    REG_SET_SEC_L  = 6'h03,
    REG_SET_NS     = 6'h04,
    REG_PERIOD     = 6'h05,
    REG_SNAP_SEC_H = 6'h06,
    REG_SNAP_SEC_L = 6'h07,
    REG_SNAP_NS    = 6'h08,
    REG_TS_SEC_H   = 6'h0A,
    REG_TS_SEC_L   = 6'h0B,
    REG_TS_NS      = 6'h0C
  } reg_addr_e;

  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [5:0]         word;
  logic               unused_addr_lsb;

  logic               irq_en_q;
  logic [47:0]        set_sec_q;
  logic [31:0]        set_ns_q;
  logic [31:0]        period_q;
  logic               time_set_q;
  logic               period_set_q;
  logic [47:0]        snap_sec_q;
  logic [31:0]        snap_ns_q;
  logic               ovf_q;
  logic               irq_q;
  logic [31:0]        data_out_q;
  logic [31:0]        rd_data_d;

  logic [47:0]        sec_mem_q [FIFO_DEPTH];
  logic [31:0]        ns_mem_q  [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;

  logic               empty;
  logic               full;
  logic               wr_ctrl;
  logic               pop;
  logic               push;
  logic               overflow;
  logic               ovf_clr;
  logic [47:0]        head_sec;
  logic [31:0]        head_ns;

  assign word            = bus.addr_in[7:2];
  assign unused_addr_lsb = ^bus.addr_in[1:0];

  // FIFO status and access decode
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_FULL);
    wr_ctrl  = bus.wr_in && (word == REG_CTRL);
    pop      = bus.rd_in && (word == REG_TS_NS) && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is taken
    push     = ts_valid_in && (!full || pop);
    overflow = ts_valid_in && full && !pop;
    ovf_clr  = bus.wr_in && (word == REG_STATUS) && bus.data_in[10];
    head_sec = empty ? '0 : sec_mem_q[rd_ptr_q];
    head_ns  = empty ? '0 : ns_mem_q[rd_ptr_q];
  end

  // Read data mux, always from pre-write register state
  always_comb begin
    rd_data_d = '0;
    case (word)
      REG_CTRL:       rd_data_d = {27'd0, irq_en_q, 4'd0};
      REG_STATUS:     rd_data_d = {21'd0, ovf_q, full, empty, 8'(level_q)};
      REG_SET_SEC_H:  rd_data_d = {16'd0, set_sec_q[47:32]};
      REG_SET_SEC_L:  rd_data_d = set_sec_q[31:0];
      REG_SET_NS:     rd_data_d = set_ns_q;
      REG_PERIOD:     rd_data_d = period_q;
      REG_SNAP_SEC_H: rd_data_d = {16'd0, snap_sec_q[47:32]};
      REG_SNAP_SEC_L: rd_data_d = snap_sec_q[31:0];
      REG_SNAP_NS:    rd_data_d = snap_ns_q;
      REG_TS_SEC_H:   rd_data_d = {16'd0, head_sec[47:32]};
      REG_TS_SEC_L:   rd_data_d = head_sec[31:0];
      REG_TS_NS:      rd_data_d = head_ns;
      default:        rd_data_d = '0;
    endcase
  end

  // Control/staging registers, load strobes, snapshot, overflow flag, IRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q     <= 1'b0;
      set_sec_q    <= '0;
      set_ns_q     <= '0;
      period_q     <= '0;
      time_set_q   <= 1'b0;
      period_set_q <= 1'b0;
      snap_sec_q   <= '0;
      snap_ns_q    <= '0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      time_set_q   <= wr_ctrl && bus.data_in[0];
      period_set_q <= wr_ctrl && bus.data_in[1];
      irq_q        <= irq_en_q && !empty;
      if (wr_ctrl) begin
        irq_en_q <= bus.data_in[4];
        if (bus.data_in[2]) begin
          snap_sec_q <= time_sec_in;
          snap_ns_q  <= time_ns_in;
        end
      end
      if (bus.wr_in) begin
        case (word)
          REG_SET_SEC_H: set_sec_q[47:32] <= bus.data_in[15:0];
          REG_SET_SEC_L: set_sec_q[31:0]  <= bus.data_in;
          REG_SET_NS:    set_ns_q         <= bus.data_in;
          REG_PERIOD:    period_q         <= bus.data_in;
          default: ;
        endcase
      end
      if (overflow)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // Timestamp FIFO storage, pointers and level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        sec_mem_q[i] <= '0;
        ns_mem_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        sec_mem_q[wr_ptr_q] <= ts_sec_in;
        ns_mem_q[wr_ptr_q]  <= ts_ns_in;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)
        level_q <= level_q + 1'b1;
      else if (pop && !push)
        level_q <= level_q - 1'b1;
    end
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_out_q <= '0;
    else if (bus.rd_in)
      data_out_q <= rd_data_d;
  end

  assign bus.data_out      = data_out_q;
  assign time_set_sec_out  = set_sec_q;
  assign time_set_ns_out   = set_ns_q;
  assign time_set_out      = time_set_q;
  assign period_out        = period_q;
  assign period_set_out    = period_set_q;
  assign irq_out           = irq_q;

endmodule

// File: tb/tb_ptp_up_reg_slave.sv
// Directed bench for ptp_up_reg_slave: register reads go through an expected-
// value queue, timestamps through a small reference FIFO model.
module tb_ptp_up_reg_slave;

  localparam int DEPTH = 4;

  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
  } ts_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] time_sec_in;
  logic [31:0] time_ns_in;
  logic [47:0] time_set_sec_out;
  logic [31:0] time_set_ns_out;
  logic        time_set_out;
  logic [31:0] period_out;
  logic        period_set_out;
  logic        ts_valid_in;
  logic [47:0] ts_sec_in;
  logic [31:0] ts_ns_in;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  ts_t         model_q[$];
  bit          model_ovf = 1'b0;

  ptp_up_reg_slave_if bus();

  ptp_up_reg_slave #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .time_sec_in      (time_sec_in),
    .time_ns_in       (time_ns_in),
    .time_set_sec_out (time_set_sec_out),
    .time_set_ns_out  (time_set_ns_out),
    .time_set_out     (time_set_out),
    .period_out       (period_out),
    .period_set_out   (period_set_out),
    .ts_valid_in      (ts_valid_in),
    .ts_sec_in        (ts_sec_in),
    .ts_ns_in         (ts_ns_in),
    .irq_out          (irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ts_t mk(input int n);
    ts_t t;
    t.sec = {16'(16'h00A0 + n), 32'(32'h0000_1000 + n)};
    t.ns  = 32'(100 + n);
    return t;
  endfunction

  function automatic logic [31:0] exp_status();
    int sz = model_q.size();
    return {21'd0, model_ovf, sz == DEPTH, sz == 0, 8'(sz)};
  endfunction

  // Model push, after any same-cycle pop has been applied
  function automatic void model_push(input ts_t t);
    if (model_q.size() < DEPTH) model_q.push_back(t);
    else model_ovf = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.wr_in = 1'b1; bus.addr_in = a; bus.data_in = d;
    tick();
    bus.wr_in = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.rd_in = 1'b1; bus.addr_in = a;
    tick();
    bus.rd_in = 1'b0;
    e = exp_q.pop_front();
    check(tag, 64'(bus.data_out), 64'(e));
  endtask

  task automatic push_ts(input ts_t t);
    ts_valid_in = 1'b1; ts_sec_in = t.sec; ts_ns_in = t.ns;
    tick();
    ts_valid_in = 1'b0;
    model_push(t);
  endtask

  // Reads SEC_H, SEC_L, NS of the head; the NS read pops
  task automatic read_ts(input string tag);
    ts_t h;
    h.sec = '0; h.ns = '0;
    if (model_q.size() > 0) h = model_q[0];
    rd({tag, "_sech"}, 8'h28, {16'd0, h.sec[47:32]});
    rd({tag, "_secl"}, 8'h2C, h.sec[31:0]);
    rd({tag, "_ns"},   8'h30, h.ns);
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  initial begin
    ts_t t;
    logic [31:0] e;
    rst = 1'b1;
    bus.wr_in = 1'b0; bus.rd_in = 1'b0; bus.addr_in = '0; bus.data_in = '0;
    time_sec_in = '0; time_ns_in = '0;
    ts_valid_in = 1'b0; ts_sec_in = '0; ts_ns_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_irq", 64'(irq_out), 64'd0);
    check("rst_time_set", 64'(time_set_out), 64'd0);
    check("rst_set_sec", 64'(time_set_sec_out), 64'd0);
    rd("rst_status", 8'h04, 32'h0000_0100);
    rd("rst_ctrl", 8'h00, 32'h0);

    // Time staging and load strobe
    wr(8'h08, 32'h0000_1234);
    wr(8'h0C, 32'h89AB_CDEF);
    wr(8'h10, 32'h0000_03E8);
    wr(8'h00, 32'h1);
    check("tset_strobe", 64'(time_set_out), 64'd1);
    check("tset_pset_idle", 64'(period_set_out), 64'd0);
    check("tset_sec", 64'(time_set_sec_out), 64'h1234_89AB_CDEF);
    check("tset_ns", 64'(time_set_ns_out), 64'd1000);
    tick();
    check("tset_strobe_off", 64'(time_set_out), 64'd0);
    rd("set_sec_h", 8'h08, 32'h0000_1234);
    rd("ctrl_selfclr", 8'h00, 32'h0);

    // Period strobe, then both strobes together
    wr(8'h14, 32'h0000_000A);
    wr(8'h00, 32'h2);
    check("pset_strobe", 64'(period_set_out), 64'd1);
    check("pset_tset_idle", 64'(time_set_out), 64'd0);
    check("pset_period", 64'(period_out), 64'hA);
    wr(8'h00, 32'h3);
    check("both_tset", 64'(time_set_out), 64'd1);
    check("both_pset", 64'(period_set_out), 64'd1);
    tick();
    check("both_off", 64'({time_set_out, period_set_out}), 64'd0);

    // Simultaneous write and read returns the old value
    bus.wr_in = 1'b1; bus.rd_in = 1'b1; bus.addr_in = 8'h14; bus.data_in = 32'h14;
    exp_q.push_back(32'hA);
    tick();
    bus.wr_in = 1'b0; bus.rd_in = 1'b0;
    e = exp_q.pop_front();
    check("wr_rd_old", 64'(bus.data_out), 64'(e));
    rd("wr_rd_new", 8'h14, 32'h14);

    // Snapshot
    time_sec_in = 48'd5; time_ns_in = 32'd999_999_999;
    wr(8'h00, 32'h4);
    time_sec_in = 48'hFFFF; time_ns_in = 32'd7;
    rd("snap_sec_l", 8'h1C, 32'd5);
    rd("snap_ns", 8'h20, 32'h3B9A_C9FF);
    rd("snap_sec_h", 8'h18, 32'd0);

    // Unmapped and read-only writes are ignored
    wr(8'h24, 32'hFFFF_FFFF);
    rd("unmapped", 8'h24, 32'd0);
    wr(8'h1C, 32'h0);
    rd("ro_snap", 8'h1C, 32'd5);

    // Fill past full with IRQ enabled
    wr(8'h00, 32'h10);
    rd("ctrl_irq_en", 8'h00, 32'h10);
    for (int i = 0; i < 5; i++) push_ts(mk(i));
    rd("status_full_ovf", 8'h04, 32'h0000_0604);
    check("irq_pending", 64'(irq_out), 64'd1);

    // Drain in push order
    for (int i = 0; i < 4; i++) read_ts($sformatf("drain%0d", i));
    check("irq_lag", 64'(irq_out), 64'd1);
    tick();
    check("irq_drop", 64'(irq_out), 64'd0);
    rd("empty_ns", 8'h30, 32'd0);
    rd("empty_sech", 8'h28, 32'd0);
    rd("status_empty_ovf", 8'h04, exp_status());

    // OVF clear, refill, then push and pop in the same cycle while full
    wr(8'h04, 32'h400);
    model_ovf = 1'b0;
    rd("ovf_cleared", 8'h04, 32'h0000_0100);
    for (int i = 10; i < 14; i++) push_ts(mk(i));
    t = mk(20);
    e = model_q[0].ns;
    exp_q.push_back(e);
    bus.rd_in = 1'b1; bus.addr_in = 8'h30;
    ts_valid_in = 1'b1; ts_sec_in = t.sec; ts_ns_in = t.ns;
    tick();
    bus.rd_in = 1'b0; ts_valid_in = 1'b0;
    void'(model_q.pop_front());
    model_push(t);
    e = exp_q.pop_front();
    check("pushpop_ns", 64'(bus.data_out), 64'(e));
    rd("pushpop_status", 8'h04, 32'h0000_0204);
    for (int i = 0; i < 4; i++) read_ts($sformatf("pp_drain%0d", i));

    // Overflow wins over a same-cycle clear
    for (int i = 30; i < 35; i++) push_ts(mk(i));
    t = mk(40);
    bus.wr_in = 1'b1; bus.addr_in = 8'h04; bus.data_in = 32'h400;
    ts_valid_in = 1'b1; ts_sec_in = t.sec; ts_ns_in = t.ns;
    tick();
    bus.wr_in = 1'b0; ts_valid_in = 1'b0;
    model_ovf = 1'b0;
    model_push(t);
    rd("ovf_set_wins", 8'h04, exp_status());
    wr(8'h04, 32'h400);
    model_ovf = 1'b0;
    rd("ovf_clear_late", 8'h04, exp_status());

    // Reset mid-operation: strobe aborted, FIFO emptied
    rd("pre_rst_read", 8'h08, 32'h0000_1234);
    wr(8'h00, 32'h11);
    check("pre_rst_strobe", 64'(time_set_out), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_strobe", 64'(time_set_out), 64'd0);
    check("mid_rst_irq", 64'(irq_out), 64'd0);
    check("mid_rst_data_out", 64'(bus.data_out), 64'd0);
    tick();
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    rd("post_rst_status", 8'h04, exp_status());
    rd("post_rst_ctrl", 8'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
